// File: rtl/reg_wb_pkg.sv
// Shared write-back types: default register/data widths and the pending-write entry.
// Used by reg_file, the execute stage and the write-back queue.
package reg_wb_pkg;
  localparam int WB_ADDR_SIZE = 5;
  localparam int WB_WORD_SIZE = 64;
  localparam int WB_DEPTH     = 4;

  typedef struct packed {
    logic [WB_ADDR_SIZE-1:0] rd;
    logic [WB_WORD_SIZE-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_wb_fifo.sv
// Pending-write storage: circular buffer with a count register for full/empty.
// All entries are presented oldest-first so the bypass search can scan by age.
module reg_wb_fifo
  import reg_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output wb_entry_t       head,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty,
  output wb_entry_t       age_entry [DEPTH],
  output logic [DEPTH-1:0] age_valid
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entry[i] = mem[rd_ptr + PW'(i)];
      age_valid[i] = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue: buffers retired results, drains one registered reg_file write per
// cycle, and offers two bypass lookups over every write not yet committed.
module reg_wb_queue
  import reg_wb_pkg::*;
#(
  parameter int ADDR_SIZE = WB_ADDR_SIZE,
  parameter int WORD_SIZE = WB_WORD_SIZE,
  parameter int DEPTH     = WB_DEPTH,
  parameter int PNDW      = $clog2(DEPTH+1)+1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_SIZE-1:0] in_rd,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 wr_stall,
  output logic                 RegWrite,
  output logic [ADDR_SIZE-1:0] wr_add,
  output logic [WORD_SIZE-1:0] wr_data,
  input  logic [ADDR_SIZE-1:0] byp_addr1,
  input  logic [ADDR_SIZE-1:0] byp_addr2,
  output logic                 byp_hit1,
  output logic [WORD_SIZE-1:0] byp_data1,
  output logic                 byp_hit2,
  output logic [WORD_SIZE-1:0] byp_data2,
  output logic [PNDW-1:0]      pending,
  output logic                 idle
);

  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t        head;
  wb_entry_t        push_entry;
  wb_entry_t        age_entry [DEPTH];
  logic [DEPTH-1:0] age_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ready_en;
  logic             accept;
  logic             push;
  logic             pop;

  // Handshake: a result transfers on the posedge where in_valid && in_ready; in_ready
  // depends only on registered state, and the producer holds in_* until the transfer.
  assign in_ready   = ready_en && !full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && (in_rd != '0);
  assign pop        = !empty && !wr_stall;
  assign push_entry = '{rd: in_rd, data: in_data};

  reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .age_entry  (age_entry),
    .age_valid  (age_valid)
  );

  // Holds in_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite <= 1'b0;
      wr_add   <= '0;
      wr_data  <= '0;
    end else if (pop) begin
      RegWrite <= 1'b1;
      wr_add   <= head.rd;
      wr_data  <= head.data;
    end else begin
      RegWrite <= 1'b0;
    end
  end

  assign pending = PNDW'(count) + PNDW'(RegWrite);
  assign idle    = empty && !RegWrite;

  // Scan oldest to youngest (output beat, then FIFO head..tail) so the last match wins.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    if (RegWrite && wr_add == byp_addr1) begin
      byp_hit1  = 1'b1;
      byp_data1 = wr_data;
    end
    if (RegWrite && wr_add == byp_addr2) begin
      byp_hit2  = 1'b1;
      byp_data2 = wr_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && age_entry[i].rd == byp_addr1) begin
        byp_hit1  = 1'b1;
        byp_data1 = age_entry[i].data;
      end
      if (age_valid[i] && age_entry[i].rd == byp_addr2) begin
        byp_hit2  = 1'b1;
        byp_data2 = age_entry[i].data;
      end
    end
    if (byp_addr1 == '0) begin
      byp_hit1  = 1'b0;
      byp_data1 = '0;
    end
    if (byp_addr2 == '0) begin
      byp_hit2  = 1'b0;
      byp_data2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: queue-level reference model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_reg_wb_queue;
  import reg_wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_data = '0;
  logic        wr_stall = 1'b0;
  logic        RegWrite;
  logic [4:0]  wr_add;
  logic [63:0] wr_data;
  logic [4:0]  byp_addr1 = '0;
  logic [4:0]  byp_addr2 = '0;
  logic        byp_hit1;
  logic [63:0] byp_data1;
  logic        byp_hit2;
  logic [63:0] byp_data2;
  logic [3:0]  pending;
  logic        idle;

  int checks   = 0;
  int failures = 0;

  reg_wb_queue #(.ADDR_SIZE(5), .WORD_SIZE(64), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .wr_stall  (wr_stall),
    .RegWrite  (RegWrite),
    .wr_add    (wr_add),
    .wr_data   (wr_data),
    .byp_addr1 (byp_addr1),
    .byp_addr2 (byp_addr2),
    .byp_hit1  (byp_hit1),
    .byp_data1 (byp_data1),
    .byp_hit2  (byp_hit2),
    .byp_data2 (byp_data2),
    .pending   (pending),
    .idle      (idle)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reg_file stand-in fed by the DUT write port ----------------
  logic [63:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (RegWrite) rf[wr_add] <= wr_data;

  // ---------------- reference model ----------------
  wb_entry_t   mq[$];
  logic        m_beat_v    = 1'b0;
  logic [4:0]  m_beat_rd   = '0;
  logic [63:0] m_beat_data = '0;
  logic        m_ready_en  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_beat_v    = 1'b0;
      m_beat_rd   = '0;
      m_beat_data = '0;
      m_ready_en  = 1'b0;
    end else begin
      logic acc;
      wb_entry_t e;
      acc = in_valid && m_ready_en && (mq.size() < DEPTH);
      if (mq.size() > 0 && !wr_stall) begin
        e = mq.pop_front();
        m_beat_v    = 1'b1;
        m_beat_rd   = e.rd;
        m_beat_data = e.data;
      end else begin
        m_beat_v = 1'b0;
      end
      if (acc && in_rd != 0) mq.push_back('{rd: in_rd, data: in_data});
      m_ready_en = 1'b1;
    end
  end

  // Youngest pending value for addr; 65-bit result {hit, data}.
  function automatic logic [64:0] model_byp(input logic [4:0] addr);
    logic [64:0] r;
    r = '0;
    if (addr == 0) return r;
    if (m_beat_v && m_beat_rd == addr) r = {1'b1, m_beat_data};
    foreach (mq[i]) if (mq[i].rd == addr) r = {1'b1, mq[i].data};
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [64:0] b1, b2;
    b1 = model_byp(byp_addr1);
    b2 = model_byp(byp_addr2);
    check("m_in_ready", 64'(in_ready), 64'(m_ready_en && mq.size() < DEPTH));
    check("m_regwrite", 64'(RegWrite), 64'(m_beat_v));
    check("m_wr_add",   64'(wr_add),   64'(m_beat_rd));
    check("m_wr_data",  wr_data,       m_beat_data);
    check("m_pending",  64'(pending),  64'(mq.size() + int'(m_beat_v)));
    check("m_idle",     64'(idle),     64'(mq.size() == 0 && !m_beat_v));
    check("m_hit1",     64'(byp_hit1), 64'(b1[64]));
    check("m_data1",    byp_data1,     b1[63:0]);
    check("m_hit2",     64'(byp_hit2), 64'(b2[64]));
    check("m_data2",    byp_data2,     b2[63:0]);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_in(input logic v, input logic [4:0] rd, input logic [63:0] d);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // 1. reset with in_valid asserted
    drive_in(1'b1, 5'd6, 64'd55);
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_idle",     64'(idle),     64'd1);
    check("rst_pending",  64'(pending),  64'd0);
    check("rst_wr_add",   64'(wr_add),   64'd0);
    drive_in(1'b0, 5'd0, 64'd0);
    rst = 1'b1;
    #1 check("rel_in_ready0", 64'(in_ready), 64'd0);
    tick();
    check("rel_in_ready1", 64'(in_ready), 64'd1);

    // 2. single write, latency
    drive_in(1'b1, 5'd1, 64'd464);
    tick();
    drive_in(1'b0, 5'd0, 64'd0);
    check("sw_regwrite_n", 64'(RegWrite), 64'd0);
    check("sw_pending_n",  64'(pending),  64'd1);
    tick();
    check("sw_regwrite", 64'(RegWrite), 64'd1);
    check("sw_wr_add",   64'(wr_add),   64'd1);
    check("sw_wr_data",  wr_data,       64'd464);
    tick();
    check("sw_regwrite_off", 64'(RegWrite), 64'd0);
    check("sw_rf1",          rf[1],         64'd464);

    // 3. fill under stall, then drain in order
    wr_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 5'(2 + i), 64'(10 + i));
      tick();
    end
    drive_in(1'b0, 5'd0, 64'd0);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_pending",  64'(pending),  64'd4);
    wr_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_regwrite", 64'(RegWrite), 64'd1);
      check("drain_wr_add",   64'(wr_add),   64'(2 + i));
      check("drain_wr_data",  wr_data,       64'(10 + i));
    end
    tick();
    check("drain_idle", 64'(idle), 64'd1);

    // 4. bypass priority
    wr_stall = 1'b1;
    drive_in(1'b1, 5'd7, 64'd100);
    tick();
    drive_in(1'b1, 5'd7, 64'd200);
    tick();
    drive_in(1'b0, 5'd0, 64'd0);
    byp_addr1 = 5'd7;
    byp_addr2 = 5'd8;
    #1;
    check("byp_hit1",  64'(byp_hit1), 64'd1);
    check("byp_data1", byp_data1,     64'd200);
    check("byp_hit2",  64'(byp_hit2), 64'd0);
    check("byp_data2", byp_data2,     64'd0);
    wr_stall = 1'b0;
    tick();
    tick();
    check("byp_beat_data1", byp_data1, 64'd200);
    check("byp_last_data",  wr_data,   64'd200);
    tick();
    check("byp_idle", 64'(idle), 64'd1);

    // 5. x0 drop
    drive_in(1'b1, 5'd0, 64'd99);
    byp_addr1 = 5'd0;
    #1 check("x0_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive_in(1'b0, 5'd0, 64'd0);
    check("x0_pending", 64'(pending),  64'd0);
    check("x0_hit1",    64'(byp_hit1), 64'd0);
    tick();
    check("x0_regwrite", 64'(RegWrite), 64'd0);

    // wrap / simultaneous push-pop with a repeating stall pattern
    byp_addr1 = 5'd3;
    byp_addr2 = 5'd5;
    for (int i = 0; i < 12; i++) begin
      drive_in(1'b1, 5'(i % 8), 64'(1000 + i));
      wr_stall = (i % 3 == 0);
      tick();
    end
    drive_in(1'b0, 5'd0, 64'd0);
    wr_stall = 1'b0;
    repeat (6) tick();
    check("wrap_idle", 64'(idle), 64'd1);
    check("wrap_rf7",  rf[7],     64'd1007);
    check("wrap_rf3",  rf[3],     64'd1011);

    // 6. reset mid-drain
    drive_in(1'b1, 5'd9, 64'd1);
    tick();
    drive_in(1'b1, 5'd10, 64'd2);
    tick();
    drive_in(1'b1, 5'd11, 64'd3);
    tick();
    drive_in(1'b0, 5'd0, 64'd0);
    check("mid_regwrite_live", 64'(RegWrite), 64'd1);
    check("mid_pending_live",  64'(pending),  64'd2);
    rst = 1'b0;
    #1;
    check("mid_regwrite_drop", 64'(RegWrite), 64'd0);
    check("mid_pending_drop",  64'(pending),  64'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (4) tick();
    check("mid_pending_after", 64'(pending),  64'd0);
    check("mid_idle_after",    64'(idle),     64'd1);
    check("mid_rf11",          rf[11],        64'd0);
    check("mid_in_ready",      64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
